// File: rtl/chronologic.sv
// chronologic: single-clock 16-entry FIFO with full/empty flags and occupancy.
// Writes when full and reads when empty are silently dropped.
// Define CHRONOLOGIC_ASSERT_EN to compile in the boundary SVA checkers.
module chronologic #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_enable,
  output logic [DATA_W-1:0] read_data,
  output logic              full_flag,
  output logic              empty_flag,
  output logic [CNT_W-1:0]  word_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              wr_ok, rd_ok;

  // flags decode straight from the count register, no extra latency
  assign full_flag  = (word_count == FULL_CNT);
  assign empty_flag = (word_count == '0);
  assign wr_ok      = write_enable & ~full_flag;
  assign rd_ok      = read_enable & ~empty_flag;

  // storage array: not reset, contents only matter once written
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= write_data;
  end

  // pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // registered read data, holds when no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     read_data <= '0;
    else if (rd_ok) read_data <= mem[rd_ptr];
  end

  // occupancy: moves only when exactly one side is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_count <= '0;
    else begin
      case ({wr_ok, rd_ok})
        2'b10:   word_count <= word_count + CNT_W'(1);
        2'b01:   word_count <= word_count - CNT_W'(1);
        default: word_count <= word_count;
      endcase
    end
  end

`ifdef CHRONOLOGIC_ASSERT_EN
  a_full_dec: assert property (@(posedge clk) disable iff (!rst_n)
    full_flag == (word_count == FULL_CNT))
    else $error("chronologic: full_flag disagrees with word_count");
  a_empty_dec: assert property (@(posedge clk) disable iff (!rst_n)
    empty_flag == (word_count == '0))
    else $error("chronologic: empty_flag disagrees with word_count");
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    word_count <= FULL_CNT)
    else $error("chronologic: word_count exceeds DEPTH");
  a_full_wr: assert property (@(posedge clk) disable iff (!rst_n)
    full_flag & write_enable & ~read_enable |=> $stable(word_count))
    else $error("chronologic: write while full changed word_count");
  a_empty_rd: assert property (@(posedge clk) disable iff (!rst_n)
    empty_flag & read_enable & ~write_enable |=> $stable(word_count))
    else $error("chronologic: read while empty changed word_count");
  a_flag_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(full_flag & empty_flag))
    else $error("chronologic: full_flag and empty_flag both set");
`else
`endif
endmodule

// File: tb/tb_chronologic.sv
// tb_chronologic: table-driven directed vectors plus hand sequences for
// full read+write collision and asynchronous reset mid-operation.
module tb_chronologic;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       write_enable;
  logic [7:0] write_data;
  logic       read_enable;
  logic [7:0] read_data;
  logic       full_flag;
  logic       empty_flag;
  logic [4:0] word_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       re;
    logic [7:0] exp_rd;
    logic [4:0] exp_cnt;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  vec_t vecs[$];

  chronologic #(.DATA_W(8), .DEPTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(read_data),
    .full_flag(full_flag), .empty_flag(empty_flag), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] rd, input logic [4:0] cnt,
                         input logic f, input logic e);
    chk({tag, " read_data"}, int'(read_data), int'(rd));
    chk({tag, " word_count"}, int'(word_count), int'(cnt));
    chk({tag, " full_flag"}, int'(full_flag), int'(f));
    chk({tag, " empty_flag"}, int'(empty_flag), int'(e));
  endtask

  // drive at negedge, let one posedge pass, return at next negedge
  task automatic step(input logic we, input logic [7:0] wd, input logic re);
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic push(input logic we, input logic [7:0] wd, input logic re,
                      input logic [7:0] rd, input logic [4:0] cnt,
                      input logic f, input logic e);
    vec_t v;
    v.we = we; v.wd = wd; v.re = re;
    v.exp_rd = rd; v.exp_cnt = cnt; v.exp_full = f; v.exp_empty = e;
    vecs.push_back(v);
  endtask

  initial begin
    // idle after reset
    push(0, 8'h00, 0, 8'h00, 5'd0, 0, 1);
    // 16 writes 0x00..0x0F
    for (int i = 0; i < 16; i++)
      push(1, 8'(i), 0, 8'h00, 5'(i + 1), (i == 15), 0);
    // write while full: dropped
    push(1, 8'hAA, 0, 8'h00, 5'd16, 1, 0);
    // 16 reads return 0x00..0x0F, never 0xAA
    for (int i = 0; i < 16; i++)
      push(0, 8'h00, 1, 8'(i), 5'(15 - i), 0, (i == 15));
    // read while empty: dropped, data holds
    push(0, 8'h00, 1, 8'h0F, 5'd0, 0, 1);
    // empty + read + write: only the write lands
    push(1, 8'h55, 1, 8'h0F, 5'd1, 0, 0);
    push(1, 8'h66, 0, 8'h0F, 5'd2, 0, 0);
    // mid-range read + write: both accepted
    push(1, 8'h77, 1, 8'h55, 5'd2, 0, 0);
    push(0, 8'h00, 1, 8'h66, 5'd1, 0, 0);
    push(0, 8'h00, 1, 8'h77, 5'd0, 0, 1);

    rst_n = 1'b0;
    write_enable = 1'b0;
    write_data = 8'h00;
    read_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("reset", 8'h00, 5'd0, 0, 1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].re);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_cnt,
              vecs[i].exp_full, vecs[i].exp_empty);
    end

    // full + read + write: read wins, written word is dropped
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0);
    chk_all("refill", 8'h77, 5'd16, 1, 0);
    step(1, 8'hCC, 1);
    chk_all("full_rw", 8'h40, 5'd15, 0, 0);
    for (int i = 1; i < 16; i++) begin
      step(0, 8'h00, 1);
      chk("drain read_data", int'(read_data), 8'h40 + i);
    end
    chk_all("drained", 8'h4F, 5'd0, 0, 1);

    // asynchronous reset mid-cycle with 5 entries stored
    for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0);
    chk("five word_count", int'(word_count), 5);
    step(0, 8'h00, 1);
    chk("pre_rst read_data", int'(read_data), 8'h90);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 8'h00, 5'd0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 1);
    chk_all("post_rst_read", 8'h00, 5'd0, 0, 1);
    step(1, 8'hE1, 0);
    step(0, 8'h00, 1);
    chk_all("post_rst_wr_rd", 8'hE1, 5'd0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
